fetch_queue: RTL

Instruction-fetch front end for the pipelined 8-bit processor. It issues program-counter reads to the instruction port of the dual-port memory and buffers the returned instructions in a small FIFO. The decode-stage IR register then loads them on its own schedule. The queue decouples memory latency from decode stalls and discards wrong-path fetches on a branch redirect. It sits directly upstream of stage 1, replacing the direct memory-to-DIR path. When the queue is empty it supplies the pipeline NOOP encoding.

---
 rtl/fetch_queue.sv | 103 ++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues PC reads to a synchronous-read memory port and
// buffers returned instructions with their PC+1 in a small FIFO for the decode stage.
module fetch_queue #(
    parameter int         DEPTH    = 4,
    parameter logic [7:0] NOOP     = 8'b00001010,
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       redirect,
    input  logic [7:0] redirect_pc,
    output logic       fetch_en,
    output logic [7:0] fetch_addr,
    input  logic [7:0] fetch_data,
    input  logic       d_ready,
    output logic       d_valid,
    output logic [7:0] d_instr,
    output logic [7:0] d_pc,
    output logic [3:0] level
);

    localparam int          PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0]  DEPTH_W5 = 5'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [7:0]    r_fetchPc;
    logic [7:0]    r_inflightPc;
    logic          r_inflight;
    logic [3:0]    r_count;
    logic [PW-1:0] r_rdPtr;
    logic [PW-1:0] r_wrPtr;
    logic [7:0]    r_instr   [DEPTH];
    logic [7:0]    r_pcPlus1 [DEPTH];

    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic          w_issue;
    logic [4:0]    w_occupancy;

    assign w_empty     = (r_count == 4'd0);
    assign w_pop       = ~w_empty & d_ready;
    assign w_push      = r_inflight & ~redirect;
    // In-flight fetch reserves a slot so the returning data always has room.
    assign w_occupancy = {1'b0, r_count} + {4'd0, r_inflight};
    assign w_issue     = reset & ~redirect & ((w_occupancy < DEPTH_W5) | w_pop);

    assign fetch_en   = w_issue;
    assign fetch_addr = r_fetchPc;
    assign d_valid    = ~w_empty;
    assign d_instr    = w_empty ? NOOP  : r_instr[r_rdPtr];
    assign d_pc       = w_empty ? 8'h00 : r_pcPlus1[r_rdPtr];
    assign level      = r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fetchPc    <= RESET_PC;
            r_inflightPc <= 8'h00;
            r_inflight   <= 1'b0;
        end else if (redirect) begin
            r_fetchPc    <= redirect_pc;
            r_inflight   <= 1'b0;
        end else if (w_issue) begin
            r_fetchPc    <= r_fetchPc + 8'd1;
            r_inflightPc <= r_fetchPc;
            r_inflight   <= 1'b1;
        end else begin
            r_inflight   <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= 4'd0;
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_instr[i]   <= 8'h00;
                r_pcPlus1[i] <= 8'h00;
            end
        end else if (redirect) begin
            // A concurrent pop is still consumed downstream; the flush discards the rest.
            r_count <= 4'd0;
            r_rdPtr <= '0;
            r_wrPtr <= '0;
        end else begin
            if (w_push) begin
                r_instr[r_wrPtr]   <= fetch_data;
                r_pcPlus1[r_wrPtr] <= r_inflightPc + 8'd1;
                r_wrPtr            <= r_wrPtr + PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
